multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS-31 datapath (RegFiles, alu, iram, dram, pc_reg, selector muxes).

---
 rtl/mips31_pkg.sv | 74 +++++++
 rtl/mc_op_decode.sv | 64 ++++++
 rtl/multicycle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips31_pkg.sv
// Shared constants for the MIPS-31 multi-cycle controller: one-hot op indices,
// ALU opcodes, FSM state codes and the decoded-instruction record.
package mips31_pkg;

   localparam int OP_ADD   = 0;
   localparam int OP_ADDU  = 1;
   localparam int OP_SUB   = 2;
   localparam int OP_SUBU  = 3;
   localparam int OP_AND   = 4;
   localparam int OP_OR    = 5;
   localparam int OP_XOR   = 6;
   localparam int OP_NOR   = 7;
   localparam int OP_SLT   = 8;
   localparam int OP_SLTU  = 9;
   localparam int OP_SLL   = 10;
   localparam int OP_SRL   = 11;
   localparam int OP_SRA   = 12;
   localparam int OP_SLLV  = 13;
   localparam int OP_SRLV  = 14;
   localparam int OP_SRAV  = 15;
   localparam int OP_JR    = 16;
   localparam int OP_ADDI  = 17;
   localparam int OP_ADDIU = 18;
   localparam int OP_ANDI  = 19;
   localparam int OP_ORI   = 20;
   localparam int OP_XORI  = 21;
   localparam int OP_LW    = 22;
   localparam int OP_SW    = 23;
   localparam int OP_BEQ   = 24;
   localparam int OP_BNE   = 25;
   localparam int OP_SLTI  = 26;
   localparam int OP_SLTIU = 27;
   localparam int OP_LUI   = 28;
   localparam int OP_J     = 29;
   localparam int OP_JAL   = 30;

   localparam logic [3:0] ALU_ADDU = 4'b0000;
   localparam logic [3:0] ALU_SUBU = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0011;
   localparam logic [3:0] ALU_AND  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0101;
   localparam logic [3:0] ALU_XOR  = 4'b0110;
   localparam logic [3:0] ALU_NOR  = 4'b0111;
   localparam logic [3:0] ALU_LUI  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1010;
   localparam logic [3:0] ALU_SLT  = 4'b1011;
   localparam logic [3:0] ALU_SRA  = 4'b1100;
   localparam logic [3:0] ALU_SRL  = 4'b1101;
   localparam logic [3:0] ALU_SLL  = 4'b1110;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      CL_NONE, CL_ALU_R, CL_ALU_I, CL_LW, CL_SW, CL_BR, CL_J, CL_JR, CL_JAL
   } op_class_t;

   typedef struct packed {
      logic [3:0] aluc;
      logic       sel_shamt;
      logic       sel_rdata2;
      logic       sign_ext;
      logic       is_beq;
      op_class_t  cls;
   } dec_t;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational decode of the latched one-hot op into ALU opcode, operand
// selects and the instruction class that steers the sequencer.
module mc_op_decode
   import mips31_pkg::*;
(
   input  logic [30:0] op,
   output dec_t        dec
);

   function automatic dec_t mk(input logic [3:0] a, input logic sh, input logic b,
                               input logic se, input op_class_t c);
      dec_t d;
      d.aluc       = a;
      d.sel_shamt  = sh;
      d.sel_rdata2 = b;
      d.sign_ext   = se;
      d.is_beq     = 1'b0;
      d.cls        = c;
      return d;
   endfunction

   always_comb begin
      dec = mk(ALU_ADDU, 1'b0, 1'b0, 1'b0, CL_NONE);
      case (1'b1)
         op[OP_ADD]:   dec = mk(ALU_ADD,  1'b0, 1'b1, 1'b0, CL_ALU_R);
         op[OP_ADDU]:  dec = mk(ALU_ADDU, 1'b0, 1'b1, 1'b0, CL_ALU_R);
         op[OP_SUB]:   dec = mk(ALU_SUB,  1'b0, 1'b1, 1'b0, CL_ALU_R);
         op[OP_SUBU]:  dec = mk(ALU_SUBU, 1'b0, 1'b1, 1'b0, CL_ALU_R);
         op[OP_AND]:   dec = mk(ALU_AND,  1'b0, 1'b1, 1'b0, CL_ALU_R);
         op[OP_OR]:    dec = mk(ALU_OR,   1'b0, 1'b1, 1'b0, CL_ALU_R);
         op[OP_XOR]:   dec = mk(ALU_XOR,  1'b0, 1'b1, 1'b0, CL_ALU_R);
         op[OP_NOR]:   dec = mk(ALU_NOR,  1'b0, 1'b1, 1'b0, CL_ALU_R);
         op[OP_SLT]:   dec = mk(ALU_SLT,  1'b0, 1'b1, 1'b0, CL_ALU_R);
         op[OP_SLTU]:  dec = mk(ALU_SLTU, 1'b0, 1'b1, 1'b0, CL_ALU_R);
         // Fixed shifts take A from shamt; variable shifts keep A=rs.
         op[OP_SLL]:   dec = mk(ALU_SLL,  1'b1, 1'b1, 1'b0, CL_ALU_R);
         op[OP_SRL]:   dec = mk(ALU_SRL,  1'b1, 1'b1, 1'b0, CL_ALU_R);
         op[OP_SRA]:   dec = mk(ALU_SRA,  1'b1, 1'b1, 1'b0, CL_ALU_R);
         op[OP_SLLV]:  dec = mk(ALU_SLL,  1'b0, 1'b1, 1'b0, CL_ALU_R);
         op[OP_SRLV]:  dec = mk(ALU_SRL,  1'b0, 1'b1, 1'b0, CL_ALU_R);
         op[OP_SRAV]:  dec = mk(ALU_SRA,  1'b0, 1'b1, 1'b0, CL_ALU_R);
         op[OP_JR]:    dec = mk(ALU_ADDU, 1'b0, 1'b0, 1'b0, CL_JR);
         op[OP_ADDI]:  dec = mk(ALU_ADD,  1'b0, 1'b0, 1'b1, CL_ALU_I);
         op[OP_ADDIU]: dec = mk(ALU_ADDU, 1'b0, 1'b0, 1'b1, CL_ALU_I);
         op[OP_ANDI]:  dec = mk(ALU_AND,  1'b0, 1'b0, 1'b0, CL_ALU_I);
         op[OP_ORI]:   dec = mk(ALU_OR,   1'b0, 1'b0, 1'b0, CL_ALU_I);
         op[OP_XORI]:  dec = mk(ALU_XOR,  1'b0, 1'b0, 1'b0, CL_ALU_I);
         op[OP_LW]:    dec = mk(ALU_ADD,  1'b0, 1'b0, 1'b1, CL_LW);
         op[OP_SW]:    dec = mk(ALU_ADD,  1'b0, 1'b0, 1'b1, CL_SW);
         op[OP_BEQ]: begin
            dec        = mk(ALU_SUBU, 1'b0, 1'b1, 1'b1, CL_BR);
            dec.is_beq = 1'b1;
         end
         op[OP_BNE]:   dec = mk(ALU_SUBU, 1'b0, 1'b1, 1'b1, CL_BR);
         op[OP_SLTI]:  dec = mk(ALU_SLT,  1'b0, 1'b0, 1'b1, CL_ALU_I);
         op[OP_SLTIU]: dec = mk(ALU_SLTU, 1'b0, 1'b0, 1'b1, CL_ALU_I);
         op[OP_LUI]:   dec = mk(ALU_LUI,  1'b0, 1'b0, 1'b0, CL_ALU_I);
         op[OP_J]:     dec = mk(ALU_ADDU, 1'b0, 1'b0, 1'b0, CL_J);
         op[OP_JAL]:   dec = mk(ALU_ADDU, 1'b0, 1'b0, 1'b0, CL_JAL);
         default:      dec = mk(ALU_ADDU, 1'b0, 1'b0, 1'b0, CL_NONE);
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-31 datapath.
// Handshake: im_r/dm_cs stay asserted until the matching *_ready; ready is ignored elsewhere.
module multicycle_ctrl
   import mips31_pkg::*;
#(
   parameter int WAIT_LIMIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [30:0] op,
   input  logic        zero,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        im_r,
   output logic        ir_we,
   output logic        pc_we,
   output logic        rf_we,
   output logic        dm_cs,
   output logic        dm_r,
   output logic        dm_w,
   output logic [8:0]  m,
   output logic [3:0]  aluc,
   output logic        illegal,
   output logic        bus_err,
   output logic [2:0]  state
);

   localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

   state_t      state_q, next_state;
   logic [30:0] op_q;
   logic [7:0]  wait_cnt;
   logic        bus_err_q;
   logic        set_err;
   dec_t        dec;

   mc_op_decode u_dec (
      .op  (op_q),
      .dec (dec)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         wait_cnt  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q <= next_state;
         if (state_q == S_DECODE && next_state == S_EXEC)
            op_q <= op;
         if (set_err)
            bus_err_q <= 1'b1;
         if ((state_q != S_FETCH && next_state == S_FETCH) ||
             (state_q != S_MEM && next_state == S_MEM))
            wait_cnt <= '0;
         else if ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready))
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_comb begin
      next_state = state_q;
      set_err    = 1'b0;
      im_r       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      rf_we      = 1'b0;
      dm_cs      = 1'b0;
      dm_r       = 1'b0;
      dm_w       = 1'b0;
      m          = '0;
      aluc       = ALU_ADDU;
      illegal    = 1'b0;

      // Operand selects stay valid from EXEC through WB for the whole instruction.
      if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
         aluc = dec.aluc;
         m[3] = dec.sel_shamt;
         m[4] = dec.sel_rdata2;
         m[6] = dec.sign_ext;
      end

      case (state_q)
         S_FETCH: begin
            im_r = 1'b1;
            if (imem_ready) begin
               ir_we      = 1'b1;
               next_state = S_DECODE;
            end else if (wait_cnt == LIMIT_M1) begin
               set_err    = 1'b1;
               next_state = S_HALT;
            end
         end
         S_DECODE: begin
            if ($countones(op) != 1) begin
               illegal    = 1'b1;
               pc_we      = 1'b1;
               next_state = S_FETCH;
            end else begin
               next_state = S_EXEC;
            end
         end
         S_EXEC: begin
            case (dec.cls)
               CL_BR: begin
                  pc_we      = 1'b1;
                  m[1]       = dec.is_beq ? zero : ~zero;
                  next_state = S_FETCH;
               end
               CL_J: begin
                  pc_we      = 1'b1;
                  m[0]       = 1'b1;
                  next_state = S_FETCH;
               end
               CL_JR: begin
                  pc_we      = 1'b1;
                  m[2]       = 1'b1;
                  next_state = S_FETCH;
               end
               CL_JAL: begin
                  pc_we      = 1'b1;
                  rf_we      = 1'b1;
                  m[0]       = 1'b1;
                  m[7]       = 1'b1;
                  next_state = S_FETCH;
               end
               CL_LW, CL_SW: next_state = S_MEM;
               default:      next_state = S_WB;
            endcase
         end
         S_MEM: begin
            dm_cs = 1'b1;
            dm_r  = (dec.cls == CL_LW);
            dm_w  = (dec.cls == CL_SW);
            if (dmem_ready) begin
               if (dec.cls == CL_SW) begin
                  pc_we      = 1'b1;
                  next_state = S_FETCH;
               end else begin
                  next_state = S_WB;
               end
            end else if (wait_cnt == LIMIT_M1) begin
               set_err    = 1'b1;
               next_state = S_HALT;
            end
         end
         S_WB: begin
            rf_we      = 1'b1;
            pc_we      = 1'b1;
            m[5]       = (dec.cls == CL_LW);
            m[8]       = (dec.cls == CL_ALU_R);
            next_state = S_FETCH;
         end
         default: next_state = S_HALT;
      endcase

      // Reset held low silences every enable immediately, aborting any access in flight.
      if (!rst) begin
         im_r    = 1'b0;
         ir_we   = 1'b0;
         pc_we   = 1'b0;
         rf_we   = 1'b0;
         dm_cs   = 1'b0;
         dm_r    = 1'b0;
         dm_w    = 1'b0;
         m       = '0;
         aluc    = ALU_ADDU;
         illegal = 1'b0;
      end
   end

   assign bus_err = rst & bus_err_q;
   assign state   = rst ? state_q : S_FETCH;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction trace model pushes expected
// per-cycle outputs into a queue that a negedge monitor pops and compares.
module tb_multicycle_ctrl;
   import mips31_pkg::*;

   logic        clk = 1'b0;
   logic        rst, zero, imem_ready, dmem_ready;
   logic [30:0] op;
   logic        im_r, ir_we, pc_we, rf_we, dm_cs, dm_r, dm_w, illegal, bus_err;
   logic [8:0]  m;
   logic [3:0]  aluc;
   logic [2:0]  state;

   always #5 clk = ~clk;

   multicycle_ctrl #(.WAIT_LIMIT(15)) dut (
      .clk(clk), .rst(rst), .op(op), .zero(zero),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .im_r(im_r), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
      .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .m(m), .aluc(aluc),
      .illegal(illegal), .bus_err(bus_err), .state(state)
   );

   localparam logic [6:0] E_IMR = 7'b1000000, E_IRWE = 7'b0100000, E_PC = 7'b0010000,
                          E_RF  = 7'b0001000, E_CS   = 7'b0000100, E_DR = 7'b0000010,
                          E_DW  = 7'b0000001;
   localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_J = 5, C_JR = 6, C_JAL = 7;

   logic [24:0] exp_q[$];
   string       name_q[$];
   int          tests = 0;
   int          fails = 0;

   int          cls_tab[31];
   logic [3:0]  alu_tab[31];
   logic [2:0]  sel_tab[31];  // {sign_ext, B=rdata2, A=shamt}

   logic [24:0] act;
   logic [24:0] mon_e;
   string       mon_n;
   assign act = {state, im_r, ir_we, pc_we, rf_we, dm_cs, dm_r, dm_w, m, aluc, illegal, bus_err};

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_n = name_q.pop_front();
         tests++;
         if (act !== mon_e) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", mon_n, act, mon_e, $time);
         end
      end
   end

   function automatic logic [24:0] ev(input logic [2:0] st, input logic [6:0] en,
                                      input logic [8:0] mm, input logic [3:0] al,
                                      input logic ill, input logic be);
      return {st, en, mm, al, ill, be};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [30:0] rnd_op();
      return 31'($urandom());
   endfunction

   function automatic logic [30:0] onehot(input int i);
      return 31'(1) << i;
   endfunction

   task automatic set_op(input int i, input int c, input logic [3:0] a, input logic [2:0] s);
      cls_tab[i] = c;
      alu_tab[i] = a;
      sel_tab[i] = s;
   endtask

   task automatic cyc(input logic r, input logic [30:0] o, input logic ir, input logic dr,
                      input logic [24:0] e, input string n);
      rst = r; op = o; imem_ready = ir; dmem_ready = dr;
      exp_q.push_back(e);
      name_q.push_back(n);
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [30:0] o, input logic z, input int fw, input int mw,
                            input string n);
      int         idx, c;
      logic [8:0] mx;
      logic [3:0] al;
      logic [6:0] rw;
      logic       taken;
      zero = z;
      for (int i = 0; i < fw; i++)
         cyc(1'b1, rnd_op(), 1'b0, rb(), ev(3'd0, E_IMR, 9'h0, 4'h0, 1'b0, 1'b0), {n, "/fetch_wait"});
      cyc(1'b1, rnd_op(), 1'b1, rb(), ev(3'd0, E_IMR | E_IRWE, 9'h0, 4'h0, 1'b0, 1'b0), {n, "/fetch"});
      if ($countones(o) != 1) begin
         cyc(1'b1, o, rb(), rb(), ev(3'd1, E_PC, 9'h0, 4'h0, 1'b1, 1'b0), {n, "/illegal"});
         return;
      end
      cyc(1'b1, o, rb(), rb(), ev(3'd1, 7'd0, 9'h0, 4'h0, 1'b0, 1'b0), {n, "/decode"});
      idx = 0;
      for (int i = 0; i < 31; i++) if (o[i]) idx = i;
      c  = cls_tab[idx];
      al = alu_tab[idx];
      mx = {2'b00, sel_tab[idx][2], 1'b0, sel_tab[idx][1], sel_tab[idx][0], 3'b000};
      case (c)
         C_BR: begin
            taken = (idx == OP_BEQ) ? z : !z;
            cyc(1'b1, rnd_op(), rb(), rb(), ev(3'd2, E_PC, mx | {7'd0, taken, 1'b0}, al, 1'b0, 1'b0), {n, "/branch"});
         end
         C_J:   cyc(1'b1, rnd_op(), rb(), rb(), ev(3'd2, E_PC, mx | 9'h001, al, 1'b0, 1'b0), {n, "/j"});
         C_JR:  cyc(1'b1, rnd_op(), rb(), rb(), ev(3'd2, E_PC, mx | 9'h004, al, 1'b0, 1'b0), {n, "/jr"});
         C_JAL: cyc(1'b1, rnd_op(), rb(), rb(), ev(3'd2, E_PC | E_RF, mx | 9'h081, al, 1'b0, 1'b0), {n, "/jal"});
         C_LW, C_SW: begin
            cyc(1'b1, rnd_op(), rb(), rb(), ev(3'd2, 7'd0, mx, al, 1'b0, 1'b0), {n, "/exec"});
            rw = (c == C_LW) ? (E_CS | E_DR) : (E_CS | E_DW);
            for (int i = 0; i < mw; i++)
               cyc(1'b1, rnd_op(), rb(), 1'b0, ev(3'd3, rw, mx, al, 1'b0, 1'b0), {n, "/mem_wait"});
            cyc(1'b1, rnd_op(), rb(), 1'b1,
                ev(3'd3, rw | ((c == C_SW) ? E_PC : 7'd0), mx, al, 1'b0, 1'b0), {n, "/mem"});
            if (c == C_LW)
               cyc(1'b1, rnd_op(), rb(), rb(), ev(3'd4, E_PC | E_RF, mx | 9'h020, al, 1'b0, 1'b0), {n, "/wb"});
         end
         default: begin
            cyc(1'b1, rnd_op(), rb(), rb(), ev(3'd2, 7'd0, mx, al, 1'b0, 1'b0), {n, "/exec"});
            cyc(1'b1, rnd_op(), rb(), rb(),
                ev(3'd4, E_PC | E_RF, mx | ((c == C_R) ? 9'h100 : 9'h000), al, 1'b0, 1'b0), {n, "/wb"});
         end
      endcase
   endtask

   initial begin
      set_op(OP_ADD,  C_R, 4'b0010, 3'b010);  set_op(OP_ADDU, C_R, 4'b0000, 3'b010);
      set_op(OP_SUB,  C_R, 4'b0011, 3'b010);  set_op(OP_SUBU, C_R, 4'b0001, 3'b010);
      set_op(OP_AND,  C_R, 4'b0100, 3'b010);  set_op(OP_OR,   C_R, 4'b0101, 3'b010);
      set_op(OP_XOR,  C_R, 4'b0110, 3'b010);  set_op(OP_NOR,  C_R, 4'b0111, 3'b010);
      set_op(OP_SLT,  C_R, 4'b1011, 3'b010);  set_op(OP_SLTU, C_R, 4'b1010, 3'b010);
      set_op(OP_SLL,  C_R, 4'b1110, 3'b011);  set_op(OP_SRL,  C_R, 4'b1101, 3'b011);
      set_op(OP_SRA,  C_R, 4'b1100, 3'b011);  set_op(OP_SLLV, C_R, 4'b1110, 3'b010);
      set_op(OP_SRLV, C_R, 4'b1101, 3'b010);  set_op(OP_SRAV, C_R, 4'b1100, 3'b010);
      set_op(OP_JR,   C_JR, 4'b0000, 3'b000);
      set_op(OP_ADDI, C_I, 4'b0010, 3'b100);  set_op(OP_ADDIU, C_I, 4'b0000, 3'b100);
      set_op(OP_ANDI, C_I, 4'b0100, 3'b000);  set_op(OP_ORI,   C_I, 4'b0101, 3'b000);
      set_op(OP_XORI, C_I, 4'b0110, 3'b000);  set_op(OP_LUI,   C_I, 4'b1000, 3'b000);
      set_op(OP_SLTI, C_I, 4'b1011, 3'b100);  set_op(OP_SLTIU, C_I, 4'b1010, 3'b100);
      set_op(OP_LW,   C_LW, 4'b0010, 3'b100); set_op(OP_SW,    C_SW, 4'b0010, 3'b100);
      set_op(OP_BEQ,  C_BR, 4'b0001, 3'b110); set_op(OP_BNE,   C_BR, 4'b0001, 3'b110);
      set_op(OP_J,    C_J, 4'b0000, 3'b000);  set_op(OP_JAL,   C_JAL, 4'b0000, 3'b000);

      rst = 1'b0; op = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      @(posedge clk);
      #1;
      cyc(1'b0, rnd_op(), rb(), rb(), ev(3'd0, 7'd0, 9'h0, 4'h0, 1'b0, 1'b0), "reset");
      cyc(1'b0, rnd_op(), rb(), rb(), ev(3'd0, 7'd0, 9'h0, 4'h0, 1'b0, 1'b0), "reset");

      run_instr(onehot(OP_ADDU), 1'b0, 0, 0, "addu");
      run_instr(onehot(OP_LW),   1'b0, 0, 3, "lw_wait3");
      run_instr(onehot(OP_BEQ),  1'b1, 0, 0, "beq_z1");
      run_instr(onehot(OP_BNE),  1'b1, 0, 0, "bne_z1");
      run_instr(onehot(OP_BEQ),  1'b0, 1, 0, "beq_z0");
      run_instr(onehot(OP_BNE),  1'b0, 0, 0, "bne_z0");
      run_instr(onehot(OP_JAL),  1'b0, 0, 0, "jal");
      run_instr(onehot(OP_J),    1'b0, 0, 0, "j");
      run_instr(onehot(OP_JR),   1'b0, 0, 0, "jr");
      run_instr(onehot(OP_SW),   1'b0, 2, 1, "sw");
      run_instr(onehot(OP_SLL),  1'b0, 0, 0, "sll");
      run_instr(onehot(OP_ANDI), 1'b0, 0, 0, "andi");
      run_instr(31'd0,           1'b0, 0, 0, "op_zero");
      run_instr(onehot(OP_ADD) | onehot(OP_LW), 1'b0, 0, 0, "op_two_bits");

      // sw aborted by reset mid-MEM
      zero = 1'b0;
      cyc(1'b1, rnd_op(), 1'b1, rb(), ev(3'd0, E_IMR | E_IRWE, 9'h0, 4'h0, 1'b0, 1'b0), "swrst/fetch");
      cyc(1'b1, onehot(OP_SW), rb(), rb(), ev(3'd1, 7'd0, 9'h0, 4'h0, 1'b0, 1'b0), "swrst/decode");
      cyc(1'b1, rnd_op(), rb(), rb(), ev(3'd2, 7'd0, 9'h040, 4'b0010, 1'b0, 1'b0), "swrst/exec");
      cyc(1'b1, rnd_op(), rb(), 1'b0, ev(3'd3, E_CS | E_DW, 9'h040, 4'b0010, 1'b0, 1'b0), "swrst/mem");
      cyc(1'b0, rnd_op(), rb(), 1'b1, ev(3'd0, 7'd0, 9'h0, 4'h0, 1'b0, 1'b0), "swrst/abort");
      run_instr(onehot(OP_ORI), 1'b0, 0, 0, "after_swrst");

      // instruction fetch timeout
      for (int i = 0; i < 15; i++)
         cyc(1'b1, rnd_op(), 1'b0, rb(), ev(3'd0, E_IMR, 9'h0, 4'h0, 1'b0, 1'b0), "timeout/wait");
      for (int i = 0; i < 4; i++)
         cyc(1'b1, rnd_op(), rb(), rb(), ev(3'd5, 7'd0, 9'h0, 4'h0, 1'b0, 1'b1), "timeout/halt");
      cyc(1'b0, rnd_op(), rb(), rb(), ev(3'd0, 7'd0, 9'h0, 4'h0, 1'b0, 1'b0), "timeout/reset");
      run_instr(onehot(OP_ADDU), 1'b0, 0, 0, "after_halt");

      // data timeout on lw
      zero = 1'b0;
      cyc(1'b1, rnd_op(), 1'b1, rb(), ev(3'd0, E_IMR | E_IRWE, 9'h0, 4'h0, 1'b0, 1'b0), "dto/fetch");
      cyc(1'b1, onehot(OP_LW), rb(), rb(), ev(3'd1, 7'd0, 9'h0, 4'h0, 1'b0, 1'b0), "dto/decode");
      cyc(1'b1, rnd_op(), rb(), rb(), ev(3'd2, 7'd0, 9'h040, 4'b0010, 1'b0, 1'b0), "dto/exec");
      for (int i = 0; i < 15; i++)
         cyc(1'b1, rnd_op(), rb(), 1'b0, ev(3'd3, E_CS | E_DR, 9'h040, 4'b0010, 1'b0, 1'b0), "dto/mem_wait");
      cyc(1'b1, rnd_op(), rb(), 1'b1, ev(3'd5, 7'd0, 9'h0, 4'h0, 1'b0, 1'b1), "dto/halt");
      cyc(1'b0, rnd_op(), rb(), rb(), ev(3'd0, 7'd0, 9'h0, 4'h0, 1'b0, 1'b0), "dto/reset");

      for (int k = 0; k < 300; k++) begin
         logic [30:0] o;
         int a, b;
         a = int'($urandom_range(0, 30));
         if ($urandom_range(0, 9) == 0) begin
            b = (a + 1 + int'($urandom_range(0, 29))) % 31;
            o = ($urandom_range(0, 1) == 0) ? 31'd0 : (onehot(a) | onehot(b));
         end else begin
            o = onehot(a);
         end
         run_instr(o, rb(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rand");
      end

      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
